mul_seq: RTL and testbench

- Sequential shift-and-add unsigned multiplier; the multiply-side counterpart of the team's sequential restoring divider.
- Computes p = a * b over W iterations, one multiplier bit per clock.
- Uses a start/busy/valid handshake so a controller can issue operations back-to-back.
- Sits beside the divider in the arithmetic datapath.

---
 rtl/mul_pkg.sv | 15 +
 rtl/mul_abs.sv | 16 +
 rtl/mul_seq.sv | 132 +++++++++++++
 tb/tb_mul_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared state encoding and sizing helper for the sequential multiplier and divider.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Iteration counter width: enough to count 0..w-1 with a spare bit.
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mul_abs.sv
// Combinational two's-complement absolute value with sign flag.
// The most-negative input maps to the unsigned magnitude 2^(W-1).
module mul_abs #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] mag,
  output logic         neg
);

  always_comb begin
    neg = x[W-1];
    mag = neg ? W'(-x) : x;
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, start/busy/valid handshake.
// Define MUL_SIGNED_EN for two's-complement operands and product.
module mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [2*W-1:0]   p,
  output logic             busy,
  output logic             valid
);

  localparam int unsigned PW    = 2 * W;
  localparam int unsigned CNT_W = cnt_w(W);

  mul_state_e       state_q, state_d;
  logic [PW-1:0]    areg_q, areg_d;
  logic [W-1:0]     breg_q, breg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  logic             accept_c;
  logic             last_c;
  logic [PW-1:0]    sum_c;
  logic [W-1:0]     a_mag_c, b_mag_c;

`ifdef MUL_SIGNED_EN
  logic a_neg_c, b_neg_c;
  logic sign_q, sign_d;

  mul_abs #(.W(W)) u_abs_a (.x(a), .mag(a_mag_c), .neg(a_neg_c));
  mul_abs #(.W(W)) u_abs_b (.x(b), .mag(b_mag_c), .neg(b_neg_c));
`else
  assign a_mag_c = a;
  assign b_mag_c = b;
`endif

  assign accept_c = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_c   = (state_q == CALC) && (cnt_q == CNT_W'(W - 1));
  assign sum_c    = acc_q + (breg_q[0] ? areg_q : PW'(0));

  // State register plus registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = CALC;
      CALC:    if (last_c)   state_d = DONE;
      DONE:    if (accept_c) state_d = CALC;
      default: state_d = IDLE;
    endcase
  end

  // Status flags decoded from the upcoming state so they are flop outputs.
  always_comb begin
    busy_d  = (state_d == CALC);
    valid_d = (state_d == DONE);
  end

  // Datapath: load on accept, shift-and-add while calculating.
  always_comb begin
    areg_d = areg_q;
    breg_d = breg_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
`ifdef MUL_SIGNED_EN
    sign_d = sign_q;
`endif
    if (accept_c) begin
      areg_d = PW'(a_mag_c);
      breg_d = b_mag_c;
      acc_d  = '0;
      cnt_d  = '0;
`ifdef MUL_SIGNED_EN
      sign_d = a_neg_c ^ b_neg_c;
`endif
    end else if (state_q == CALC) begin
      acc_d  = sum_c;
      areg_d = areg_q << 1;
      breg_d = breg_q >> 1;
      cnt_d  = cnt_q + CNT_W'(1);
`ifdef MUL_SIGNED_EN
      // Negate on the final iteration so the signed product lands with no extra cycle.
      if (last_c && sign_q) acc_d = PW'(-sum_c);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      areg_q <= '0;
      breg_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
`ifdef MUL_SIGNED_EN
      sign_q <= 1'b0;
`endif
    end else begin
      areg_q <= areg_d;
      breg_q <= breg_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
`ifdef MUL_SIGNED_EN
      sign_q <= sign_d;
`endif
    end
  end

  assign p     = acc_q;
  assign busy  = busy_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corners, back-to-back, reset abort and random operands.
module tb_mul_seq;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 2 * W;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [PW-1:0] p;
  logic          busy;
  logic          valid;

  int total;
  int bad;

  mul_seq #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .p     (p),
    .busy  (busy),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product from plain integer arithmetic.
  function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy;
`ifdef MUL_SIGNED_EN
    sx = longint'($signed(x));
    sy = longint'($signed(y));
`else
    sx = longint'(x);
    sy = longint'(y);
`endif
    return PW'(sx * sy);
  endfunction

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    total++;
    if (p !== '0 || busy !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL reset: p=%h busy=%b valid=%b required p=00 busy=0 valid=0", p, busy, valid);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b valid=%b required 0 0", busy, valid);
    end
  endtask

  // One operation: accept ta/tb, drive ca/cb during the calculation, check latency and result.
  task automatic test_single_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                                input logic [W-1:0] ca, input logic [W-1:0] cb,
                                input logic [PW-1:0] exp);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb;
    @(negedge clk);
    start = 1'b0; a = ca; b = cb;
    for (int j = 0; j < int'(W); j++) begin
      total++;
      if (busy !== 1'b1 || valid !== 1'b0) begin
        bad++;
        $display("FAIL %s_busy cycle %0d: busy=%b valid=%b required 1 0", name, j, busy, valid);
      end
      @(negedge clk);
    end
    total++;
    if (valid !== 1'b1 || busy !== 1'b0 || p !== exp) begin
      bad++;
      $display("FAIL %s: p=%h valid=%b busy=%b required p=%h valid=1 busy=0", name, p, valid, busy, exp);
    end
    repeat (3) @(negedge clk);
    total++;
    if (valid !== 1'b1 || p !== exp) begin
      bad++;
      $display("FAIL %s_hold: p=%h valid=%b required p=%h valid=1", name, p, valid, exp);
    end
  endtask

  task automatic test_corners();
`ifdef MUL_SIGNED_EN
    test_single_op("s_m3x5",  4'hD, 4'h5, 4'h0, 4'h0, 8'hF1);
    test_single_op("s_m8xm8", 4'h8, 4'h8, 4'h1, 4'h1, 8'h40);
    test_single_op("s_m8x7",  4'h8, 4'h7, 4'h3, 4'h3, 8'hC8);
    test_single_op("s_0x9",   4'h0, 4'h9, 4'hF, 4'hF, 8'h00);
`else
    test_single_op("u_13x11", 4'd13, 4'd11, 4'd0, 4'd0, 8'h8F);
    test_single_op("u_15x15", 4'd15, 4'd15, 4'd0, 4'd0, 8'hE1);
    test_single_op("u_0x9",   4'd0,  4'd9,  4'd5, 4'd5, 8'h00);
    test_single_op("u_7x0",   4'd7,  4'd0,  4'd3, 4'd3, 8'h00);
`endif
  endtask

  task automatic test_operand_change();
    test_single_op("opchange", 4'd9, 4'd9, 4'd1, 4'd1, model(4'd9, 4'd9));
  endtask

  // Start held high: second operands presented during CALC must be ignored until DONE.
  task automatic test_back_to_back();
    logic [PW-1:0] e1, e2;
    logic          exp_valid;
    e1 = model(4'd3, 4'd5);
    e2 = model(4'd6, 4'd7);
    @(negedge clk);
    start = 1'b1; a = 4'd3; b = 4'd5;
    @(negedge clk);
    a = 4'd6; b = 4'd7;
    for (int j = 0; j <= 2 * int'(W) + 1; j++) begin
      exp_valid = (j == int'(W)) || (j == 2 * int'(W) + 1);
      total++;
      if (valid !== exp_valid || busy !== !exp_valid) begin
        bad++;
        $display("FAIL b2b_flags cycle %0d: valid=%b busy=%b required valid=%b busy=%b",
                 j, valid, busy, exp_valid, !exp_valid);
      end
      if (j == int'(W)) begin
        total++;
        if (p !== e1) begin
          bad++;
          $display("FAIL b2b_first: p=%h required %h", p, e1);
        end
      end
      if (j == 2 * int'(W) + 1) begin
        total++;
        if (p !== e2) begin
          bad++;
          $display("FAIL b2b_second: p=%h required %h", p, e2);
        end
        start = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if (valid !== 1'b1 || p !== e2) begin
      bad++;
      $display("FAIL b2b_hold: p=%h valid=%b required p=%h valid=1", p, valid, e2);
    end
  endtask

  task automatic test_reset_mid_calc();
    @(negedge clk);
    start = 1'b1; a = 4'd11; b = 4'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || valid !== 1'b0 || p !== '0) begin
      bad++;
      $display("FAIL reset_mid_calc: p=%h busy=%b valid=%b required p=00 busy=0 valid=0", p, busy, valid);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    total++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle: busy=%b valid=%b required 0 0", busy, valid);
    end
    test_single_op("after_reset", 4'd2, 4'd2, 4'd0, 4'd0, 8'h04);
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      test_single_op("random", ra, rb, W'($urandom), W'($urandom), model(ra, rb));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_corners();
    test_operand_change();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
